// File: rtl/bus_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_8
//  Purpose  : Round-robin arbiter and sequencer for the shared 8:1 datapath
//             bus. Grants one requester at a time, drives the mux select and
//             registers the selected source word onto the bus. A burst limit
//             forces a handoff whenever another source is waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_8 #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [WIDTH-1:0] in_3,
    input  logic [WIDTH-1:0] in_4,
    input  logic [WIDTH-1:0] in_5,
    input  logic [WIDTH-1:0] in_6,
    input  logic [WIDTH-1:0] in_7,
    output logic [7:0]       grant,
    output logic [2:0]       select,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic             busy
);

    // Counter must be able to hold MAX_BURST itself; it saturates there.
    localparam int C_CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [C_CNT_W-1:0] C_MAX_BURST = C_CNT_W'(MAX_BURST);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

    // The arbiter state lives in the registered grant vector itself.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]         r_grant;
    logic [2:0]         r_select;
    logic [WIDTH-1:0]   r_bus_out;
    logic               r_bus_valid;
    logic [C_CNT_W-1:0] r_burst_cnt;
    logic [2:0]         r_rr_ptr;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_src [8];
    logic [0:0]         w_state;
    logic [2:0]         w_pick_base;
    logic [2:0]         w_pick_idx;
    logic               w_pick_valid;
    logic [7:0]         w_nxt_grant;
    logic [2:0]         w_nxt_select;
    logic [C_CNT_W-1:0] w_nxt_cnt;
    logic [2:0]         w_nxt_ptr;
    logic               w_load;

    assign w_src[0] = in_0;
    assign w_src[1] = in_1;
    assign w_src[2] = in_2;
    assign w_src[3] = in_3;
    assign w_src[4] = in_4;
    assign w_src[5] = in_5;
    assign w_src[6] = in_6;
    assign w_src[7] = in_7;

    assign w_state = (|r_grant) ? ST_OWN : ST_IDLE;

    // While idle the search starts after the stored pointer; while owning,
    // a release makes the current owner the new pointer, so search after it.
    assign w_pick_base = (w_state == ST_IDLE) ? r_rr_ptr : r_select;

    // Round-robin search: scan base+8 (the base itself) down to base+1 so the
    // closest requester after the base overwrites every farther one.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            if (req[w_pick_base + 3'(i)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_pick_base + 3'(i);
            end
        end
    end

    // Next owner, burst count and pointer for the coming edge.
    always_comb begin
        w_nxt_grant  = r_grant;
        w_nxt_select = r_select;
        w_nxt_cnt    = r_burst_cnt;
        w_nxt_ptr    = r_rr_ptr;
        case (w_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_nxt_grant  = 8'(1) << w_pick_idx;
                    w_nxt_select = w_pick_idx;
                    w_nxt_cnt    = C_CNT_ONE;
                end
            end
            ST_OWN: begin
                if (req[r_select] && (r_burst_cnt < C_MAX_BURST)) begin
                    w_nxt_cnt = r_burst_cnt + C_CNT_ONE;
                end else begin
                    // Release: zero-bubble handoff, re-grant of a lone owner,
                    // or fall back to idle when nobody is asking.
                    w_nxt_ptr = r_select;
                    if (w_pick_valid) begin
                        w_nxt_grant  = 8'(1) << w_pick_idx;
                        w_nxt_select = w_pick_idx;
                        w_nxt_cnt    = C_CNT_ONE;
                    end else begin
                        w_nxt_grant = 8'd0;
                        w_nxt_cnt   = '0;
                    end
                end
            end
            default: begin
                w_nxt_grant = 8'd0;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Data is valid only when the post-edge owner is still requesting.
    assign w_load = (|w_nxt_grant) && req[w_nxt_select];

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= 8'd0;
            r_select    <= 3'd0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= 3'd7;
        end else begin
            r_grant     <= w_nxt_grant;
            r_select    <= w_nxt_select;
            r_burst_cnt <= w_nxt_cnt;
            r_rr_ptr    <= w_nxt_ptr;
        end
    end

    // Bus data register; holds its last word whenever nothing valid is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
        end else begin
            r_bus_valid <= w_load;
            if (w_load) begin
                r_bus_out <= w_src[w_nxt_select];
            end
        end
    end

    assign grant     = r_grant;
    assign select    = r_select;
    assign bus_out   = r_bus_out;
    assign bus_valid = r_bus_valid;
    assign busy      = |r_grant;

endmodule
`default_nettype wire
